// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and widths for the Booth result collector
package booth_pkg;

  localparam int HALF_W_C = 6;
  localparam int PROD_W_C = 12;

  typedef enum logic {
    IDLE,
    BEAT1
  } coll_state_t;

  typedef logic signed [PROD_W_C-1:0] prod_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous product FIFO with registered head and occupancy count
module result_fifo
  import booth_pkg::*;
#(
  parameter int WIDTH = PROD_W_C,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     accepted,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_pop;
  logic             do_push;

  // Qualify push/pop, advance pointers and work out the next head value.
  // A pop frees the head slot first, so a push into a full FIFO still lands.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // head holds its last value once the FIFO drains
    head_d = head_q;
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  // Pointer, occupancy and registered head state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only read once written, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign accepted = do_push;
  assign head     = head_q;
  assign valid    = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/booth_result_collector.sv
// rtl/booth_result_collector.sv - reassembles two-beat Booth products into a FIFO; BOOTH_ACCUM_EN adds an accumulator
module booth_result_collector
  import booth_pkg::*;
#(
  parameter int HALF_W   = HALF_W_C,
  parameter int DEPTH    = 4,
  parameter int HI_FIRST = 1,
  parameter int ACC_W    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HALF_W-1:0]        inbus,
  input  logic                     ready,
  output logic [2*HALF_W-1:0]      prod_data,
  output logic                     prod_valid,
  input  logic                     prod_ack,
  output logic                     mult_hold,
  output logic                     overflow,
`ifdef BOOTH_ACCUM_EN
  input  logic                     acc_clr,
  output logic [ACC_W-1:0]         acc_out,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PROD_W = 2 * HALF_W;

  coll_state_t       state_q, state_d;
  logic [HALF_W-1:0] beat0_q;
  logic              beat0_en;
  logic              push;
  logic [PROD_W-1:0] push_data;
  logic              accepted;
  logic              overflow_q;
  int                free_slots;

  // Capture FSM: strobe latches beat0, the following cycle always supplies beat1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat0_q <= '0;
    end else begin
      state_q <= state_d;
      if (beat0_en) begin
        beat0_q <= inbus;
      end
    end
  end

  // Next state and product assembly; ready is ignored while in BEAT1.
  always_comb begin
    state_d   = state_q;
    beat0_en  = 1'b0;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      IDLE: begin
        if (ready) begin
          beat0_en = 1'b1;
          state_d  = BEAT1;
        end
      end
      BEAT1: begin
        push    = 1'b1;
        state_d = IDLE;
        if (HI_FIRST != 0) begin
          push_data = {beat0_q, inbus};
        end else begin
          push_data = {inbus, beat0_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  result_fifo #(
    .WIDTH (PROD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (prod_ack),
    .accepted  (accepted),
    .head      (prod_data),
    .valid     (prod_valid),
    .count     (count)
  );

  // Hold the sequencer once at most one slot remains, counting a product mid-capture.
  always_comb begin
    free_slots = DEPTH - int'(count) - ((state_q == BEAT1) ? 1 : 0);
    mult_hold  = (free_slots <= 1);
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push && !accepted) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

`ifdef BOOTH_ACCUM_EN
  logic [ACC_W-1:0] acc_q;

  // Running sum of accepted products; clear wins over a same-cycle add.
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      acc_q <= '0;
    end else if (accepted) begin
      acc_q <= acc_q + {{(ACC_W-PROD_W){push_data[PROD_W-1]}}, push_data};
    end
  end

  assign acc_out = acc_q;
`endif

endmodule

// File: tb/tb_booth_result_collector.sv
// tb/tb_booth_result_collector.sv - randomized self-checking bench for booth_result_collector (BOOTH_ACCUM_EN optional)
module tb_booth_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        prod_ack;
  logic [5:0]  inbus;
  logic [11:0] prod_data;
  logic        prod_valid;
  logic        mult_hold;
  logic        overflow;
  logic [2:0]  count;
`ifdef BOOTH_ACCUM_EN
  logic        acc_clr;
  logic [19:0] acc_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  // transaction-level reference: queue of stored products, sticky drop flag, last head, running sum
  logic [11:0] mq[$];
  logic        m_ovf;
  logic [11:0] m_last;
  logic [19:0] m_acc;

  always #5 clk = ~clk;

  booth_result_collector dut (
    .clk        (clk),
    .rst        (rst),
    .inbus      (inbus),
    .ready      (ready),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ack   (prod_ack),
    .mult_hold  (mult_hold),
    .overflow   (overflow),
`ifdef BOOTH_ACCUM_EN
    .acc_clr    (acc_clr),
    .acc_out    (acc_out),
`endif
    .count      (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_last = '0;
    m_acc  = '0;
  endtask

  task automatic model_push(input logic [11:0] p, input bit ack, input bit clr);
    if (ack && mq.size() > 0) void'(mq.pop_front());
    if (mq.size() < DEPTH) begin
      mq.push_back(p);
      m_acc = m_acc + 20'(signed'(p));
    end else begin
      m_ovf = 1'b1;
    end
    if (clr) m_acc = '0;
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic model_pop();
    if (mq.size() > 0) void'(mq.pop_front());
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; inbus = '0; prod_ack = 1'b0;
`ifdef BOOTH_ACCUM_EN
    acc_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  // two-beat product, high half first; ready is randomized during the ignored beat
  task automatic send(input logic [11:0] p, input bit ack, input bit clr);
    ready = 1'b1; inbus = p[11:6]; prod_ack = 1'b0;
    tick();
    ready = 1'($urandom_range(0, 1)); inbus = p[5:0]; prod_ack = ack;
`ifdef BOOTH_ACCUM_EN
    acc_clr = clr;
`endif
    tick();
    ready = 1'b0; prod_ack = 1'b0;
`ifdef BOOTH_ACCUM_EN
    acc_clr = 1'b0;
`endif
    model_push(p, ack, clr);
  endtask

  task automatic pop_one();
    ready = 1'b0; prod_ack = 1'b1;
    tick();
    prod_ack = 1'b0;
    model_pop();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (prod_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", prod_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (prod_data !== 12'h000) begin miscompares++; $display("FAIL reset_data got=%h exp=000", prod_data); end
    vectors++; if (mult_hold !== 1'b0) begin miscompares++; $display("FAIL reset_hold got=%b exp=0", mult_hold); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
`ifdef BOOTH_ACCUM_EN
    vectors++; if (acc_out !== 20'd0) begin miscompares++; $display("FAIL reset_acc got=%h exp=0", acc_out); end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    ready = 1'b1; inbus = 6'h3F;
    tick();
    ready = 1'b0; inbus = 6'h38;
    vectors++; if (prod_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got=%b exp=0", prod_valid); end
    tick();
    vectors++; if (prod_data !== 12'hFF8) begin miscompares++; $display("FAIL basic_data got=%h exp=FF8", prod_data); end
    vectors++; if ($signed(prod_data) !== -12'sd8) begin miscompares++; $display("FAIL basic_signed got=%0d exp=-8", $signed(prod_data)); end
    vectors++; if (prod_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b exp=1", prod_valid); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL basic_count got=%0d exp=1", count); end
  endtask

  task automatic test_fill_overflow();
    logic [11:0] first;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      send(12'($urandom), 1'b0, 1'b0);
      vectors++; if (count !== 3'(i + 1)) begin miscompares++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
      vectors++; if (mult_hold !== ((i + 1) >= DEPTH - 1)) begin miscompares++; $display("FAIL fill_hold n=%0d got=%b", i + 1, mult_hold); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    end
    first = mq[0];
    send(12'($urandom), 1'b0, 1'b0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_ovf got=%b exp=1", overflow); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL drop_count got=%0d exp=4", count); end
    vectors++; if (prod_data !== first) begin miscompares++; $display("FAIL drop_head got=%h exp=%h", prod_data, first); end
  endtask

  task automatic test_full_push_pop();
    logic [11:0] last_p;
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(12'($urandom), 1'b0, 1'b0);
    last_p = 12'($urandom);
    send(last_p, 1'b1, 1'b0);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fullpp_count got=%0d exp=4", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++; if (prod_data !== mq[0]) begin miscompares++; $display("FAIL fullpp_drain%0d got=%h exp=%h", i, prod_data, mq[0]); end
      pop_one();
    end
    vectors++; if (prod_data !== last_p) begin miscompares++; $display("FAIL fullpp_hold got=%h exp=%h", prod_data, last_p); end
    vectors++; if (prod_valid !== 1'b0) begin miscompares++; $display("FAIL fullpp_empty got=%b exp=0", prod_valid); end
    pop_one();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL pop_empty_count got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b1; inbus = 6'h15;
    tick();
    ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL midrst_count got=%0d exp=0", count); end
    send(12'h042, 1'b0, 1'b0);
    vectors++; if (prod_data !== 12'h042) begin miscompares++; $display("FAIL midrst_data got=%h exp=042", prod_data); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL midrst_n got=%0d exp=1", count); end
  endtask

  task automatic test_ready_held();
    logic [5:0] b [4];
    do_reset();
    for (int i = 0; i < 4; i++) b[i] = 6'($urandom);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inbus = b[i];
      tick();
    end
    ready = 1'b0; inbus = b[3];
    tick();
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL held_count got=%0d exp=2", count); end
    vectors++; if (prod_data !== {b[0], b[1]}) begin miscompares++; $display("FAIL held_p0 got=%h exp=%h", prod_data, {b[0], b[1]}); end
    prod_ack = 1'b1;
    tick();
    prod_ack = 1'b0;
    vectors++; if (prod_data !== {b[2], b[3]}) begin miscompares++; $display("FAIL held_p1 got=%h exp=%h", prod_data, {b[2], b[3]}); end
  endtask

  task automatic test_random();
    logic [11:0] p;
    bit ack;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pop_one();
      end else begin
        p = 12'($urandom);
        ack = 1'($urandom_range(0, 1));
        ready = 1'b1; inbus = p[11:6]; prod_ack = 1'b0;
        tick();
        vectors++; if (mult_hold !== ((DEPTH - mq.size() - 1) <= 1)) begin miscompares++; $display("FAIL rnd_hold_beat1 n=%0d got=%b occ=%0d", n, mult_hold, mq.size()); end
        ready = 1'($urandom_range(0, 1)); inbus = p[5:0]; prod_ack = ack;
        tick();
        ready = 1'b0; prod_ack = 1'b0;
        model_push(p, ack, 1'b0);
      end
      vectors++; if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
      vectors++; if (prod_valid !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_valid n=%0d got=%b", n, prod_valid); end
      vectors++; if (prod_data !== m_last) begin miscompares++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, prod_data, m_last); end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
      vectors++; if (mult_hold !== ((DEPTH - mq.size()) <= 1)) begin miscompares++; $display("FAIL rnd_hold n=%0d got=%b", n, mult_hold); end
`ifdef BOOTH_ACCUM_EN
      vectors++; if (acc_out !== m_acc) begin miscompares++; $display("FAIL rnd_acc n=%0d got=%h exp=%h", n, acc_out, m_acc); end
`endif
    end
  endtask

`ifdef BOOTH_ACCUM_EN
  task automatic test_accum();
    do_reset();
    send(12'd100, 1'b1, 1'b0);
    vectors++; if (acc_out !== 20'd100) begin miscompares++; $display("FAIL acc_100 got=%0d exp=100", acc_out); end
    send(12'hFE2, 1'b1, 1'b0);
    vectors++; if (acc_out !== 20'd70) begin miscompares++; $display("FAIL acc_70 got=%0d exp=70", acc_out); end
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    vectors++; if (acc_out !== 20'd0) begin miscompares++; $display("FAIL acc_clr got=%0d exp=0", acc_out); end
    send(12'd7, 1'b1, 1'b0);
    vectors++; if (acc_out !== 20'd7) begin miscompares++; $display("FAIL acc_7 got=%0d exp=7", acc_out); end
    send(12'd5, 1'b1, 1'b1);
    vectors++; if (acc_out !== 20'd0) begin miscompares++; $display("FAIL acc_clr_push got=%0d exp=0", acc_out); end
    send(12'hFFF, 1'b1, 1'b0);
    vectors++; if (acc_out !== 20'hFFFFF) begin miscompares++; $display("FAIL acc_wrap got=%h exp=FFFFF", acc_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_ready_held();
    test_random();
`ifdef BOOTH_ACCUM_EN
    test_accum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
